// File: rtl/mp64_rst_seq.sv
// mp64_rst_seq: platform reset sequencer and heartbeat generator.
//
// A single board-level reset (rst) plus an external level request
// (ext_rst_req, synchronised here) and a synchronous soft reset pulse
// (soft_rst_req) drive a HOLD -> RELEASE -> RUN sequence. After HOLD_CYCLES
// quiet clocks, domain 0 leaves reset. Each further domain follows
// STAGE_GAP clocks later, in index order. A reset event in RELEASE or RUN
// re-enters HOLD and bumps a saturating event counter.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset (everything, incl. rst_count)
//   ext_rst_req   asynchronous external reset request, level, active-high
//   soft_rst_req  synchronous single-cycle soft reset pulse
//   dom_rst_n     per-domain active-low resets, registered
//   all_released  high once every domain is out of reset
//   state_o       FSM state: 0=HOLD, 1=RELEASE, 2=RUN
//   debug_leds    8'h00 in HOLD, {4'h1, idx} in RELEASE, heartbeat in RUN
//   rst_count     saturating count of re-entries into HOLD
module mp64_rst_seq #(
    parameter int unsigned N_DOMAINS     = 4,
    parameter int unsigned HOLD_CYCLES   = 8,
    parameter int unsigned STAGE_GAP     = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter logic [7:0]  HEARTBEAT_PAT = 8'hA5,
    parameter int unsigned BLINK_CYCLES  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ext_rst_req,
    input  logic                 soft_rst_req,
    output logic [N_DOMAINS-1:0] dom_rst_n,
    output logic                 all_released,
    output logic [1:0]           state_o,
    output logic [7:0]           debug_leds,
    output logic [7:0]           rst_count
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned GAP_W  = $clog2(STAGE_GAP + 1);
    // +2 keeps the width non-zero when blinking is disabled
    localparam int unsigned BLK_W  = $clog2(BLINK_CYCLES + 2);

    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(STAGE_GAP - 1);
    localparam logic [BLK_W-1:0]     BLK_LAST  = BLK_W'(BLINK_CYCLES - 1);
    localparam logic [3:0]           IDX_LAST  = 4'(N_DOMAINS - 1);
    localparam logic [N_DOMAINS-1:0] DOM_ONE   = N_DOMAINS'(1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   rst_event;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic [BLK_W-1:0]       blink_cnt;
    logic [BLK_W-1:0]       blink_nxt;
    logic [3:0]             idx;
    logic [3:0]             idx_nxt;

    // ext_rst_req synchroniser; req_s is the last flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ext_rst_req};
        end
    end

    assign req_s     = sync_q[SYNC_STAGES-1];
    // Coincident soft and external requests collapse into one event
    assign rst_event = req_s | soft_rst_req;
    assign idx_nxt   = idx + 4'd1;
    assign state_o   = state;

    // Blink counter runs 0..BLINK_CYCLES-1; the LEDs flip whenever it lands
    // on the last value, so the first flip is BLINK_CYCLES-1 edges after RUN
    // entry and later ones every BLINK_CYCLES edges.
    always_comb begin
        blink_nxt = blink_cnt + BLK_W'(1);
        if (blink_cnt == BLK_LAST) begin
            blink_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_HOLD;
            dom_rst_n    <= '0;
            all_released <= 1'b0;
            debug_leds   <= 8'h00;
            rst_count    <= 8'h00;
            hold_cnt     <= '0;
            gap_cnt      <= '0;
            blink_cnt    <= '0;
            idx          <= '0;
        end else if (rst_event) begin
            // Only a re-entry from RELEASE/RUN counts; an event while
            // already in HOLD just restarts the hold interval.
            if (state != S_HOLD && rst_count != 8'hFF) begin
                rst_count <= rst_count + 8'd1;
            end
            state        <= S_HOLD;
            dom_rst_n    <= '0;
            all_released <= 1'b0;
            debug_leds   <= 8'h00;
            hold_cnt     <= '0;
            gap_cnt      <= '0;
            blink_cnt    <= '0;
            idx          <= '0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt  <= '0;
                        gap_cnt   <= '0;
                        idx       <= '0;
                        dom_rst_n <= DOM_ONE;
                        if (N_DOMAINS == 1) begin
                            state        <= S_RUN;
                            all_released <= 1'b1;
                            debug_leds   <= HEARTBEAT_PAT;
                            blink_cnt    <= '0;
                        end else begin
                            state      <= S_RELEASE;
                            debug_leds <= 8'h10;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt   <= '0;
                        idx       <= idx_nxt;
                        // Domains release strictly in index order, so the
                        // next one is always the lowest bit still low.
                        dom_rst_n <= (dom_rst_n << 1) | DOM_ONE;
                        if (idx_nxt == IDX_LAST) begin
                            state        <= S_RUN;
                            all_released <= 1'b1;
                            debug_leds   <= HEARTBEAT_PAT;
                            blink_cnt    <= '0;
                        end else begin
                            debug_leds <= {4'h1, idx_nxt};
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                S_RUN: begin
                    if (BLINK_CYCLES != 0) begin
                        blink_cnt <= blink_nxt;
                        if (blink_nxt == BLK_LAST) begin
                            debug_leds <= ~debug_leds;
                        end
                    end
                end
                default: begin
                    state <= S_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp64_rst_seq.sv
`timescale 1ns/1ps
module tb_mp64_rst_seq;

    logic sim_clk = 1'b0;
    logic rst;
    logic ext_rst_req;
    logic soft_rst_req;

    always #5 sim_clk = ~sim_clk;

    // Three instances: default, single-domain short hold, blinking
    logic [3:0] d0_dom;  logic d0_all; logic [1:0] d0_st; logic [7:0] d0_leds; logic [7:0] d0_cnt;
    logic [0:0] d1_dom;  logic d1_all; logic [1:0] d1_st; logic [7:0] d1_leds; logic [7:0] d1_cnt;
    logic [3:0] d2_dom;  logic d2_all; logic [1:0] d2_st; logic [7:0] d2_leds; logic [7:0] d2_cnt;

    mp64_rst_seq #(.N_DOMAINS(4), .HOLD_CYCLES(8), .STAGE_GAP(4), .SYNC_STAGES(2),
                   .HEARTBEAT_PAT(8'hA5), .BLINK_CYCLES(0)) u_def (
        .clk(sim_clk), .rst(rst), .ext_rst_req(ext_rst_req), .soft_rst_req(soft_rst_req),
        .dom_rst_n(d0_dom), .all_released(d0_all), .state_o(d0_st),
        .debug_leds(d0_leds), .rst_count(d0_cnt));

    mp64_rst_seq #(.N_DOMAINS(1), .HOLD_CYCLES(3), .STAGE_GAP(4), .SYNC_STAGES(2),
                   .HEARTBEAT_PAT(8'hA5), .BLINK_CYCLES(0)) u_one (
        .clk(sim_clk), .rst(rst), .ext_rst_req(ext_rst_req), .soft_rst_req(soft_rst_req),
        .dom_rst_n(d1_dom), .all_released(d1_all), .state_o(d1_st),
        .debug_leds(d1_leds), .rst_count(d1_cnt));

    mp64_rst_seq #(.N_DOMAINS(4), .HOLD_CYCLES(8), .STAGE_GAP(4), .SYNC_STAGES(2),
                   .HEARTBEAT_PAT(8'hA5), .BLINK_CYCLES(4)) u_blk (
        .clk(sim_clk), .rst(rst), .ext_rst_req(ext_rst_req), .soft_rst_req(soft_rst_req),
        .dom_rst_n(d2_dom), .all_released(d2_all), .state_o(d2_st),
        .debug_leds(d2_leds), .rst_count(d2_cnt));

    logic [15:0] a_dom [3];
    logic        a_all [3];
    logic [1:0]  a_st  [3];
    logic [7:0]  a_leds[3];
    logic [7:0]  a_cnt [3];

    assign a_dom[0] = {12'd0, d0_dom};
    assign a_dom[1] = {15'd0, d1_dom};
    assign a_dom[2] = {12'd0, d2_dom};
    assign a_all[0] = d0_all;  assign a_all[1] = d1_all;  assign a_all[2] = d2_all;
    assign a_st[0]  = d0_st;   assign a_st[1]  = d1_st;   assign a_st[2]  = d2_st;
    assign a_leds[0] = d0_leds; assign a_leds[1] = d1_leds; assign a_leds[2] = d2_leds;
    assign a_cnt[0] = d0_cnt;  assign a_cnt[1] = d1_cnt;  assign a_cnt[2] = d2_cnt;

    // Reference model: outputs are a pure function of the number of quiet
    // edges since the last reset event ("since"), plus an event counter.
    int cfg_n    [3] = '{4, 1, 4};
    int cfg_hold [3] = '{8, 3, 8};
    int cfg_gap  [3] = '{4, 4, 4};
    int cfg_blink[3] = '{0, 0, 4};
    int since_m  [3];
    int cnt_m    [3];
    logic ext_q[$];

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            since_m[i] = 0;
            cnt_m[i]   = 0;
        end
        ext_q.delete();
        ext_q.push_back(1'b0);
        ext_q.push_back(1'b0);
    endtask

    task automatic model_edge(input logic s, input logic e);
        logic req;
        req = ext_q.pop_front();
        ext_q.push_back(e);
        for (int i = 0; i < 3; i++) begin
            if (s || req) begin
                if (since_m[i] >= cfg_hold[i] && cnt_m[i] < 255) cnt_m[i]++;
                since_m[i] = 0;
            end else begin
                since_m[i]++;
            end
        end
    endtask

    function automatic void model_out(input int i, output logic [15:0] dom, output logic all,
                                      output logic [1:0] st, output logic [7:0] leds);
        int rel;
        int full;
        int r;
        rel = 0;
        for (int k = 0; k < cfg_n[i]; k++)
            if (since_m[i] >= cfg_hold[i] + k * cfg_gap[i]) rel++;
        dom  = 16'((1 << rel) - 1);
        all  = (rel == cfg_n[i]);
        full = cfg_hold[i] + (cfg_n[i] - 1) * cfg_gap[i];
        if (rel == 0) begin
            st = 2'd0; leds = 8'h00;
        end else if (!all) begin
            st = 2'd1; leds = {4'h1, 4'(rel - 1)};
        end else begin
            st = 2'd2; leds = 8'hA5;
            if (cfg_blink[i] != 0) begin
                r = since_m[i] - full;
                if (((r + 1) / cfg_blink[i]) % 2 == 1) leds = ~leds;
            end
        end
    endfunction

    task automatic chk(input string nm, input int d, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d edge %0d got %h want %h", nm, d, edge_no, act, exp);
        end
    endtask

    task automatic check_all();
        logic [15:0] ed; logic ea; logic [1:0] es; logic [7:0] el;
        for (int i = 0; i < 3; i++) begin
            model_out(i, ed, ea, es, el);
            chk("dom_rst_n", i, a_dom[i], ed);
            chk("all_released", i, {15'd0, a_all[i]}, {15'd0, ea});
            chk("state_o", i, {14'd0, a_st[i]}, {14'd0, es});
            chk("debug_leds", i, {8'd0, a_leds[i]}, {8'd0, el});
            chk("rst_count", i, {8'd0, a_cnt[i]}, 16'(cnt_m[i]));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_dom"}, i, a_dom[i], 16'h0000);
            chk({tag, "_all"}, i, {15'd0, a_all[i]}, 16'h0000);
            chk({tag, "_st"}, i, {14'd0, a_st[i]}, 16'h0000);
            chk({tag, "_leds"}, i, {8'd0, a_leds[i]}, 16'h0000);
            chk({tag, "_cnt"}, i, {8'd0, a_cnt[i]}, 16'h0000);
        end
    endtask

    // One clock: drive inputs, advance model at the edge, check at negedge
    task automatic step(input logic s, input logic e);
        soft_rst_req = s;
        ext_rst_req  = e;
        @(posedge sim_clk);
        model_edge(s, e);
        edge_no++;
        @(negedge sim_clk);
        check_all();
    endtask

    typedef struct {
        int         edge_no;
        logic [3:0] dom;
        logic       all;
        logic [1:0] st;
        logic [7:0] leds;
    } vec_t;

    vec_t       tbl[8];
    logic [7:0] blink_exp[8];

    initial begin
        #500000;
        $display("FAIL watchdog edge %0d", edge_no);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic er;
        tbl[0] = '{7,  4'b0000, 1'b0, 2'd0, 8'h00};
        tbl[1] = '{8,  4'b0001, 1'b0, 2'd1, 8'h10};
        tbl[2] = '{11, 4'b0001, 1'b0, 2'd1, 8'h10};
        tbl[3] = '{12, 4'b0011, 1'b0, 2'd1, 8'h11};
        tbl[4] = '{16, 4'b0111, 1'b0, 2'd1, 8'h12};
        tbl[5] = '{19, 4'b0111, 1'b0, 2'd1, 8'h12};
        tbl[6] = '{20, 4'b1111, 1'b1, 2'd2, 8'hA5};
        tbl[7] = '{27, 4'b1111, 1'b1, 2'd2, 8'hA5};
        blink_exp = '{8'hA5, 8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'hA5};

        rst = 1'b1; ext_rst_req = 1'b0; soft_rst_req = 1'b0;
        model_reset();
        #3;
        chk_reset_vals("reset");
        repeat (2) @(negedge sim_clk);
        rst = 1'b0;
        edge_no = 0;

        // Power-on release sequence
        for (int v = 0; v < 8; v++) begin
            while (edge_no < tbl[v].edge_no) begin
                step(1'b0, 1'b0);
                if (edge_no == 2) chk("one_pre", 1, {14'd0, d1_st}, 16'd0);
                if (edge_no == 3) begin
                    chk("one_dom", 1, {15'd0, d1_dom}, 16'd1);
                    chk("one_st", 1, {14'd0, d1_st}, 16'd2);
                    chk("one_all", 1, {15'd0, d1_all}, 16'd1);
                end
                if (edge_no >= 20 && edge_no <= 27)
                    chk("blink_leds", 2, {8'd0, d2_leds}, {8'd0, blink_exp[edge_no - 20]});
            end
            chk("tbl_dom", 0, {12'd0, d0_dom}, {12'd0, tbl[v].dom});
            chk("tbl_all", 0, {15'd0, d0_all}, {15'd0, tbl[v].all});
            chk("tbl_st", 0, {14'd0, d0_st}, {14'd0, tbl[v].st});
            chk("tbl_leds", 0, {8'd0, d0_leds}, {8'd0, tbl[v].leds});
        end

        // Soft reset from RUN, then full re-release 20 edges later
        step(1'b1, 1'b0);
        chk("soft_dom", 0, {12'd0, d0_dom}, 16'h0);
        chk("soft_st", 0, {14'd0, d0_st}, 16'h0);
        chk("soft_cnt", 0, {8'd0, d0_cnt}, 16'd1);
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b0);
            if (i == 19) chk("soft_rel19", 0, {12'd0, d0_dom}, 16'h7);
            if (i == 20) begin
                chk("soft_rel20", 0, {12'd0, d0_dom}, 16'hF);
                chk("soft_all20", 0, {15'd0, d0_all}, 16'h1);
            end
        end

        // External request held for 10 cycles
        step(1'b0, 1'b1);
        chk("ext_a0", 0, {12'd0, d0_dom}, 16'hF);
        step(1'b0, 1'b1);
        chk("ext_a1", 0, {12'd0, d0_dom}, 16'hF);
        step(1'b0, 1'b1);
        chk("ext_a2", 0, {12'd0, d0_dom}, 16'h0);
        repeat (7) step(1'b0, 1'b1);
        for (int i = 1; i <= 9; i++) step(1'b0, 1'b0);
        chk("ext_a18", 0, {12'd0, d0_dom}, 16'h0);
        step(1'b0, 1'b0);
        chk("ext_a19", 0, {12'd0, d0_dom}, 16'h1);
        chk("ext_cnt", 0, {8'd0, d0_cnt}, 16'd2);

        // Async rst mid-release with two domains out
        repeat (4) step(1'b0, 1'b0);
        chk("mid_dom", 0, {12'd0, d0_dom}, 16'h3);
        chk("mid_st", 0, {14'd0, d0_st}, 16'h1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async");
        model_reset();
        repeat (2) @(negedge sim_clk);
        rst = 1'b0;
        edge_no = 0;

        // Coincident soft request and synchronised external request
        repeat (20) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("both_cnt", 0, {8'd0, d0_cnt}, 16'd1);
        chk("both_dom", 0, {12'd0, d0_dom}, 16'h0);
        step(1'b0, 1'b0);

        // Randomised traffic against the model
        er = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 14) == 0) er = ~er;
            step(($urandom_range(0, 29) == 0), er);
        end

        // Saturation of the event counter
        for (int i = 0; i < 300; i++) begin
            repeat (9) step(1'b0, 1'b0);
            step(1'b1, 1'b0);
        end
        chk("sat_cnt", 0, {8'd0, d0_cnt}, 16'hFF);
        chk("sat_cnt", 1, {8'd0, d1_cnt}, 16'hFF);
        chk("sat_cnt", 2, {8'd0, d2_cnt}, 16'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
